// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence player.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ON,
    ST_GAP,
    ST_FIN
  } play_state_e;

  // ms-tick = 2**PRESC_SHIFT sub-ticks; sub-tick period = ticks_per_milli >> PRESC_SHIFT
  localparam int PRESC_SHIFT = 4;

  // Tone half-period in sub-ticks, indexed by colour (0..3)
  localparam logic [3:0][4:0] TONE_HALF = {5'd12, 5'd16, 5'd19, 5'd24};

  // Sub-tick period in clock cycles, never allowed to collapse to zero
  function automatic logic [15:0] sub_period(input logic [15:0] tpm);
    logic [15:0] p;
    p = tpm >> PRESC_SHIFT;
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/simon_tone_gen.sv
// Square-wave tone generator for the Simon player: toggles the output every
// half_i sub-ticks while enabled; clr_i forces phase back to zero.
// Only built when SIMON_PLAYER_SOUND_EN is defined.
`ifdef SIMON_PLAYER_SOUND_EN
module simon_tone_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       sub_tick_i,
  input  logic [4:0] half_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       wave_o
);

  logic [4:0] cnt_q, cnt_d;
  logic       wave_q, wave_d;

  // Count sub-ticks and flip the wave each time a half period completes
  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (clr_i) begin
      cnt_d  = 5'd0;
      wave_d = 1'b0;
    end else if (en_i && sub_tick_i) begin
      if (cnt_q == half_i - 5'd1) begin
        cnt_d  = 5'd0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Tone state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 5'd0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule
`endif

// File: rtl/simon_sequence_player.sv
// Simon sequence playback controller: walks step memory 0..length-1, lighting
// each step's LED (with tone) for on_ms then a dark gap of gap_ms.
// Tone output is built only when SIMON_PLAYER_SOUND_EN is defined; otherwise
// sound is tied low and LED/FSM timing is identical.
module simon_sequence_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 32,
  localparam int LW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   ticks_per_milli,
  input  logic          start,
  input  logic          abort,
  input  logic [LW-1:0] length,
  input  logic [7:0]    on_ms,
  input  logic [7:0]    gap_ms,
  output logic [LW-1:0] step_addr,
  input  logic [1:0]    step_data,
  output logic [3:0]    led,
  output logic          sound,
  output logic          busy,
  output logic          done
);

  localparam logic [LW:0] MAX_LEN_W = (LW+1)'(MAX_LEN);

  play_state_e state_q, state_d;
  logic [LW:0] len_q, len_d, idx_q, idx_d, idx_inc, len_clamp;
  logic [7:0]  on_q, on_d, gap_q, gap_d, ms_q, ms_d;
  logic [1:0]  color_q, color_d;
  logic [15:0] per_q, per_d, pre_q, pre_d;
  logic [3:0]  sub_q, sub_d;
  logic        sub_tick, ms_tick, cnt_clr, step_done;

  assign len_clamp = ({1'b0, length} > MAX_LEN_W) ? MAX_LEN_W : {1'b0, length};
  assign idx_inc   = idx_q + (LW+1)'(1);
  assign sub_tick  = (pre_q == per_q - 16'd1);
  assign ms_tick   = sub_tick && (sub_q == 4'd15);

  // Next-state logic: sequence walk, parameter latching, abort override
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    on_d      = on_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    color_d   = color_q;
    step_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          on_d    = (on_ms == 8'd0) ? 8'd1 : on_ms;
          gap_d   = gap_ms;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        color_d = step_data;
        state_d = ST_ON;
      end
      ST_ON: begin
        if (ms_tick && ms_q == on_q - 8'd1) begin
          if (gap_q != 8'd0) state_d = ST_GAP;
          else               step_done = 1'b1;
        end
      end
      ST_GAP: begin
        if (ms_tick && ms_q == gap_q - 8'd1) step_done = 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (step_done) begin
      idx_d   = idx_inc;
      state_d = (idx_inc < len_q) ? ST_FETCH : ST_FIN;
    end
    if (abort && state_q != ST_IDLE && state_q != ST_FIN) state_d = ST_FIN;
  end

  // Prescaler: sub-tick and ms counters restart on every state entry; a new
  // ticks_per_milli is picked up only when the sub-tick counter wraps
  assign cnt_clr = (state_q == ST_IDLE) || (state_d != state_q);

  always_comb begin
    pre_d = pre_q + 16'd1;
    sub_d = sub_q;
    ms_d  = ms_q;
    per_d = per_q;
    if (cnt_clr) begin
      pre_d = 16'd0;
      sub_d = 4'd0;
      ms_d  = 8'd0;
      per_d = sub_period(ticks_per_milli);
    end else if (sub_tick) begin
      pre_d = 16'd0;
      per_d = sub_period(ticks_per_milli);
      sub_d = sub_q + 4'd1;
      if (sub_q == 4'd15) ms_d = ms_q + 8'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      on_q    <= 8'd0;
      gap_q   <= 8'd0;
      ms_q    <= 8'd0;
      color_q <= 2'd0;
      per_q   <= 16'd1;
      pre_q   <= 16'd0;
      sub_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      gap_q   <= gap_d;
      ms_q    <= ms_d;
      color_q <= color_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      sub_q   <= sub_d;
    end
  end

  assign step_addr = idx_q[LW-1:0];
  assign led       = (state_q == ST_ON) ? (4'b0001 << color_q) : 4'b0000;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);

`ifdef SIMON_PLAYER_SOUND_EN
  logic tone_w;

  simon_tone_gen u_tone (
    .clk        (clk),
    .rst        (rst),
    .sub_tick_i (sub_tick),
    .half_i     (TONE_HALF[color_q]),
    .en_i       (state_q == ST_ON),
    .clr_i      (state_q != ST_ON),
    .wave_o     (tone_w)
  );

  assign sound = (state_q == ST_ON) & tone_w;
`else
  assign sound = 1'b0;
`endif

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player: expected LED/done events are
// queued when a playback is launched and matched as the DUT produces them.
module tb_simon_sequence_player;

  localparam int P = 6;  // sub-tick period for ticks_per_milli = 100

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm;
  logic        start, abort;
  logic [4:0]  length, step_addr;
  logic [7:0]  on_ms, gap_ms;
  logic [1:0]  step_data;
  logic [3:0]  led;
  logic        sound, busy, done;

  logic [1:0]  mem [32];

  always #5 clk = ~clk;

  // Step memory with one-cycle read latency
  always @(posedge clk) step_data <= mem[step_addr];

  simon_sequence_player dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (tpm),
    .start           (start),
    .abort           (abort),
    .length          (length),
    .on_ms           (on_ms),
    .gap_ms          (gap_ms),
    .step_addr       (step_addr),
    .step_data       (step_data),
    .led             (led),
    .sound           (sound),
    .busy            (busy),
    .done            (done)
  );

  int cyc = 0;
  int s   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         dn;
    logic [3:0] v;
    int         t;
  } ev_t;
  ev_t q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk_ev(input bit dn, input logic [3:0] v, input int t);
    ev_t e;
    e.dn = dn;
    e.v  = v;
    e.t  = t;
    return e;
  endfunction

  function automatic int half_of(input logic [3:0] l);
    case (l)
      4'b0001: return 24;
      4'b0010: return 19;
      4'b0100: return 16;
      4'b1000: return 12;
      default: return 0;
    endcase
  endfunction

  task automatic take(input bit dn, input logic [3:0] v, input int t);
    ev_t e;
    if (q.size() == 0) begin
      chk(dn ? "unexp_done" : "unexp_led", 1, 0);
    end else begin
      e = q.pop_front();
      chk("ev_kind", dn, e.dn);
      chk(dn ? "done_val" : "led_val", v, e.v);
      chk(dn ? "done_time" : "led_time", t, e.t);
    end
  endtask

  // Monitor: sample outputs on the falling edge, timestamps relative to start
  bit         mon_en = 1'b0;
  logic [3:0] led_p  = 4'd0;
  logic       snd_p  = 1'b0;
  int         mt, snd_t;

  always @(negedge clk) begin
    if (mon_en) begin
      mt = cyc - s;
      if (led !== led_p) begin
        take(1'b0, led, mt);
        if (led != 4'd0) begin
          chk("snd_ph0", sound, 0);
          snd_t = mt;
        end
      end
`ifdef SIMON_PLAYER_SOUND_EN
      if (sound !== snd_p && led != 4'd0) begin
        chk("snd_half", mt - snd_t, half_of(led) * P);
        snd_t = mt;
      end
      if (led == 4'd0 && sound !== 1'b0) chk("snd_dark", sound, 0);
`else
      if (sound !== 1'b0) chk("snd_off", sound, 0);
`endif
      if (done) take(1'b1, 4'd0, mt);
      led_p = led;
      snd_p = sound;
    end
  end

  // Launch a playback, queue its expected events, then run it to completion.
  // ab_t: cycle to pulse abort (0 = never); re_t: cycle to re-issue start with
  // length 1 (0 = never); ab0: assert abort together with start.
  task automatic play(input int L, input int O, input int G,
                      input int ab_t, input int re_t, input bit ab0);
    ev_t lq[$];
    int t, ton, toff, oe, fin_t;
    logic [3:0] lit;
    oe = (O == 0) ? 1 : O;
    t  = 1;
    for (int i = 0; i < L; i++) begin
      ton  = t + 2;
      lq.push_back(mk_ev(1'b0, 4'(1 << mem[i]), ton));
      toff = ton + oe * 16 * P;
      lq.push_back(mk_ev(1'b0, 4'd0, toff));
      t    = toff + G * 16 * P;
    end
    lq.push_back(mk_ev(1'b1, 4'd0, t));
    if (ab_t > 0) begin
      lit = 4'd0;
      foreach (lq[i]) begin
        if (lq[i].t <= ab_t) begin
          q.push_back(lq[i]);
          if (!lq[i].dn) lit = lq[i].v;
        end
      end
      if (lit != 4'd0) q.push_back(mk_ev(1'b0, 4'd0, ab_t + 1));
      q.push_back(mk_ev(1'b1, 4'd0, ab_t + 1));
      fin_t = ab_t + 1;
    end else begin
      foreach (lq[i]) q.push_back(lq[i]);
      fin_t = t;
    end

    @(negedge clk);
    length = L[4:0];
    on_ms  = O[7:0];
    gap_ms = G[7:0];
    start  = 1'b1;
    abort  = ab0;
    s      = cyc;
    for (int k = 1; k <= fin_t + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == ab_t);
      if (k == re_t) begin
        start  = 1'b1;
        length = 5'd1;
      end
      if (k == fin_t)     chk("busy_fin", busy, 1);
      if (k == fin_t + 1) chk("busy_idle", busy, 0);
    end
    @(negedge clk);
    chk("sb_drain", q.size(), 0);
    q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    tpm    = 16'd100;
    length = 5'd0;
    on_ms  = 8'd0;
    gap_ms = 8'd0;
    foreach (mem[i]) mem[i] = 2'd0;

    #12;
    chk("rst_led", led, 0);
    chk("rst_sound", sound, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", step_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    led_p  = led;
    snd_p  = sound;
    mon_en = 1'b1;

    // abort while idle does nothing
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    @(negedge clk);
    chk("idle_abort_done", done, 0);

    // reference sequence {2,0,3}
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(3, 2, 1, 0, 0, 1'b0);

    // empty sequence
    play(0, 2, 1, 0, 0, 1'b0);

    // abort during step 1 ON
    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd2;
    play(3, 1, 1, 230, 0, 1'b0);

    // start+abort together, re-start while busy, zero gap
    mem[0] = 2'd3; mem[1] = 2'd1;
    play(2, 1, 0, 0, 50, 1'b1);

    // on_ms = 0 behaves as 1
    mem[0] = 2'd3;
    play(1, 0, 2, 0, 0, 1'b0);

    // asynchronous reset in the middle of step 1 GAP
    mon_en = 1'b0;
    mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3;
    @(negedge clk);
    length = 5'd3;
    on_ms  = 8'd1;
    gap_ms = 8'd1;
    start  = 1'b1;
    s      = cyc;
    for (int k = 1; k <= 330; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_addr", step_addr, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_sound", sound, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", step_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    led_p  = led;
    snd_p  = sound;
    mon_en = 1'b1;

    // replay after reset starts from step 0
    mem[0] = 2'd0; mem[1] = 2'd2;
    play(2, 1, 1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Playback controller for the Simon game: on `start`, it walks the stored colour sequence from step 0 to `length-1`. For each step it lights that step's LED and drives its tone for `on_ms` milliseconds, then holds a silent, dark gap of `gap_ms` milliseconds. It sits between the game FSM, which owns the step memory and the round length, and the `led`/`sound` pads, and is the only driver of them during playback. All time bases derive from `ticks_per_milli`, so the slow-clock test mode works unchanged.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum sequence length; `length`/`step_addr` width is clog2(MAX_LEN).

Ports (reset is asynchronous, active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  async active-high reset.
- `ticks_per_milli`  in  16  clock cycles per millisecond.
- `start`  in  1  one-cycle request to begin playback; ignored while `busy`.
- `abort`  in  1  stop playback immediately.
- `length`  in  5  number of steps to play, sampled at `start`.
- `on_ms`  in  8  lit/tone duration per step, sampled at `start`.
- `gap_ms`  in  8  dark gap after each step, sampled at `start`.
- `step_addr`  out  5  step memory read address.
- `step_data`  in  2  colour at `step_addr`, valid one cycle after the address.
- `led`  out  4  one-hot LED drive.
- `sound`  out  1  speaker square wave.
- `busy`  out  1  high from the cycle after `start` until return to IDLE.
- `done`  out  1  one-cycle pulse when playback completes or aborts.

## Operation
- Prescaler: sub-tick period P = max(ticks_per_milli >> 4, 1) cycles. A ms-tick occurs every 16 sub-ticks. Both counters clear on every state entry.
- FSM states:
  - IDLE → FETCH on `start`. `length`, `on_ms` and `gap_ms` are latched and `idx` is cleared.
  - FETCH drives `step_addr` = `idx`, then moves to LOAD.
  - LOAD captures `step_data` into `color`, then moves to ON.
  - ON: `led` = 1<<`color` and the tone is enabled. After `on_ms` ms-ticks the FSM moves to GAP.
  - GAP: `led` = 0 and `sound` = 0. After `gap_ms` ms-ticks, `idx` increments. The FSM then goes to FETCH if `idx` < `length`, else to FIN.
  - FIN pulses `done` and moves to IDLE.
- `length` = 0: IDLE → FIN directly. `done` pulses and the LED never lights.
- `length` > `MAX_LEN` is clamped to `MAX_LEN`.
- `on_ms` = 0 is treated as 1. `gap_ms` = 0 skips GAP entirely.
- `abort` in any non-IDLE state goes to FIN next cycle, with `led`/`sound` forced to 0 that cycle. `abort` in IDLE has no effect. If `abort` and `start` are both asserted in IDLE, `start` wins.
- Tone: `sound` toggles every H sub-ticks while in ON, where H by colour is 0→24, 1→19, 2→16, 3→12 (≈333/421/500/667 Hz at nominal rate). The tone phase resets to 0 on entering ON.
- `ticks_per_milli` changing mid-playback takes effect at the next prescaler wrap.

## Timing
- Reset values: `led` = 0, `sound` = 0, `busy` = 0, `done` = 0, `step_addr` = 0, state = IDLE.
- `start` at cycle 0: FETCH at cycle 1, LOAD at 2, `led` valid from cycle 3.
- ON lasts exactly `on_ms`·16·P cycles.
- GAP lasts `gap_ms`·16·P cycles.
- Per-step overhead is 2 cycles (FETCH, LOAD).
- `done` is high for exactly one cycle, in FIN. `busy` falls in the cycle after FIN.
- `step_data` is sampled only in LOAD.

## Configuration
- `SIMON_PLAYER_SOUND_EN` defined: the tone generator is instantiated and `sound` behaves as above.
- Undefined: no tone logic is built, `sound` is tied to 0, and LED/FSM timing is unchanged.

## Structure
- Package `simon_pkg`: player state enum, tone half-period table (4×5 bits), prescaler shift constant (4).
- Sub-module `simon_tone_gen`: sub-tick input, 5-bit half-period, enable and phase reset; outputs the square wave. It is compiled only under the macro.

## Test plan
- `ticks_per_milli`=100 (P=6), `length`=3, memory {2,0,3}, `on_ms`=2, `gap_ms`=1 → `led` is 0100 for 192 cycles, off for 96, then 0001, then 1000. `done` pulses once. Total 3·(2+192+96)+2 cycles.
- `length`=0 → `done` pulses in the cycle after `start`, and `led` stays 0.
- `abort` mid-ON at step 1 → next cycle `led`=0 and `sound`=0, `done` pulses, `busy` falls one cycle later.
- `start` while busy with different `length` → ignored; the original sequence completes unchanged.
- Colour 3 in ON with P=6 → `sound` toggles every 72 cycles, with the first toggle 72 cycles after ON entry. Without the macro, `sound` stays 0 throughout.
- `rst` asserted mid-GAP → all outputs 0 immediately (async). After release, a new `start` plays from step 0.
